// File: rtl/bit_trace_recorder_if.sv
// Control, probe and drain-stream signals of the bit trace recorder.
// The recorder takes the slave side; whoever drives start/stop/probes and consumes the stream takes the master side.
interface bit_trace_recorder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              stop;
  logic              smp_in;
  logic              smp_load;
  logic              smp_out;
  logic              busy;
  logic              full;
  logic [ADDR_W:0]   cap_count;
  logic              rd_valid;
  logic [2:0]        rd_data;
  logic              rd_last;
  logic              rd_ready;

  modport slave (
    input  start, stop, smp_in, smp_load, smp_out, rd_ready,
    output busy, full, cap_count, rd_valid, rd_data, rd_last
  );

  modport master (
    output start, stop, smp_in, smp_load, smp_out, rd_ready,
    input  busy, full, cap_count, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/bit_trace_recorder.sv
// Records {in, load, out} once per clock into a DEPTH-entry buffer, then drains it as a valid/ready stream.
// First entry is valid 1 cycle after DRAIN entry; back-to-back thereafter; rd_ready low holds the registered output.
module bit_trace_recorder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bit_trace_recorder_if.slave  bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;

  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  logic [1:0]      state;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] rd_ptr;
  logic            full_q;
  logic            rd_valid_q;
  logic            rd_last_q;
  logic [2:0]      rd_data_q;
  logic [2:0]      mem [DEPTH];

  logic wr_en;
  logic rd_en;
  logic hs;

  always_comb begin
    wr_en = (state == CAPTURE) && !bus.stop;
    hs    = rd_valid_q && bus.rd_ready;
    // Refill the output register whenever it is empty or being consumed this cycle.
    rd_en = (state == DRAIN) && (rd_ptr != cnt) && (!rd_valid_q || bus.rd_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_ptr     <= '0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= CAPTURE;
            cnt    <= '0;
            full_q <= 1'b0;
          end
        end
        CAPTURE: begin
          if (bus.stop) begin
            state  <= DRAIN;
            rd_ptr <= '0;
          end else begin
            cnt <= cnt + ONE;
            if (cnt == LAST_IDX) begin
              full_q <= 1'b1;
              state  <= DRAIN;
              rd_ptr <= '0;
            end
          end
        end
        DRAIN: begin
          if (rd_en) begin
            rd_valid_q <= 1'b1;
            rd_last_q  <= (rd_ptr == cnt - ONE);
            rd_ptr     <= rd_ptr + ONE;
          end else if (hs) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
          end
          if ((hs && rd_last_q) || (cnt == '0)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage and read register carry no reset; rd_data is only meaningful under rd_valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt[ADDR_W-1:0]] <= {bus.smp_in, bus.smp_load, bus.smp_out};
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_ptr[ADDR_W-1:0]];
    end
  end

  assign bus.busy      = (state == CAPTURE);
  assign bus.full      = full_q;
  assign bus.cap_count = cnt;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
endmodule

// File: tb/tb_bit_trace_recorder.sv
// Directed, table-driven bench for bit_trace_recorder: inputs change and outputs are sampled on the falling edge.
module tb_bit_trace_recorder;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  typedef struct {
    logic [2:0] smp;
    logic [2:0] exp_data;
    logic       exp_last;
  } vec_t;

  logic clk;
  logic rst_n;

  bit_trace_recorder_if #(.ADDR_W(ADDR_W)) intf ();

  bit_trace_recorder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [2:0] exp_q [$];
  logic [2:0] got_d [$];
  logic       got_l [$];
  vec_t       tbl [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_smp(input logic [2:0] v);
    {intf.smp_in, intf.smp_load, intf.smp_out} = v;
  endtask

  // start, one stored sample per exp_q entry, then stop; returns at the DRAIN-entry negedge.
  task automatic run_capture(input bit hold_start);
    intf.start = 1'b1;
    tick();
    intf.start = hold_start;
    foreach (exp_q[i]) begin
      set_smp(exp_q[i]);
      tick();
    end
    intf.stop = 1'b1;
    tick();
    intf.stop  = 1'b0;
    intf.start = 1'b0;
  endtask

  task automatic drain(input bit toggle, input bit pulse_start, input bit chk_first);
    bit         done  = 1'b0;
    bit         stall = 1'b0;
    logic [2:0] hd    = '0;
    logic       hl    = 1'b0;
    int         first = -1;
    got_d.delete();
    got_l.delete();
    for (int c = 0; c < 2000 && !done; c++) begin
      intf.rd_ready = toggle ? c[0] : 1'b1;
      intf.start    = pulse_start && (c == 1);
      if (stall) begin
        chk("stall_valid", intf.rd_valid, 1'b1);
        chk("stall_data", intf.rd_data, hd);
        chk("stall_last", intf.rd_last, hl);
      end
      if (first < 0 && intf.rd_valid) first = c;
      if (intf.rd_valid && intf.rd_ready) begin
        got_d.push_back(intf.rd_data);
        got_l.push_back(intf.rd_last);
        if (intf.rd_last) done = 1'b1;
      end
      stall = intf.rd_valid && !intf.rd_ready;
      hd    = intf.rd_data;
      hl    = intf.rd_last;
      tick();
    end
    intf.start    = 1'b0;
    intf.rd_ready = 1'b0;
    chk("drain_completed", done, 1'b1);
    if (chk_first) chk("first_valid_within_2", (first >= 0 && first <= 2), 1'b1);
    chk("valid_falls_after_last", intf.rd_valid, 1'b0);
    chk("busy_after_drain", intf.busy, 1'b0);
  endtask

  task automatic cmp_drain(input string tag);
    chk({tag, "_count"}, got_d.size(), exp_q.size());
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      chk({tag, "_data"}, got_d[i], exp_q[i]);
      chk({tag, "_last"}, got_l[i], (i == exp_q.size() - 1));
    end
  endtask

  initial begin
    tbl[0] = '{3'b110, 3'b110, 1'b0};
    tbl[1] = '{3'b111, 3'b111, 1'b0};
    tbl[2] = '{3'b011, 3'b011, 1'b0};
    tbl[3] = '{3'b000, 3'b000, 1'b0};
    tbl[4] = '{3'b101, 3'b101, 1'b1};

    rst_n         = 1'b0;
    intf.start    = 1'b0;
    intf.stop     = 1'b0;
    intf.rd_ready = 1'b0;
    set_smp(3'b000);
    tick();
    chk("rst_busy", intf.busy, 1'b0);
    chk("rst_full", intf.full, 1'b0);
    chk("rst_cap_count", intf.cap_count, 0);
    chk("rst_rd_valid", intf.rd_valid, 1'b0);
    chk("rst_rd_last", intf.rd_last, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic capture, compared straight against the vector table.
    exp_q.delete();
    foreach (tbl[i]) exp_q.push_back(tbl[i].smp);
    intf.start = 1'b1;
    tick();
    chk("basic_busy", intf.busy, 1'b1);
    chk("basic_start_count", intf.cap_count, 0);
    intf.start = 1'b0;
    foreach (tbl[i]) begin
      set_smp(tbl[i].smp);
      tick();
    end
    intf.stop = 1'b1;
    tick();
    intf.stop = 1'b0;
    chk("basic_cap_count", intf.cap_count, 5);
    chk("basic_full", intf.full, 1'b0);
    chk("basic_busy_drain", intf.busy, 1'b0);
    drain(1'b0, 1'b0, 1'b1);
    chk("basic_drain_count", got_d.size(), 5);
    for (int i = 0; i < 5 && i < got_d.size(); i++) begin
      chk("basic_data", got_d[i], tbl[i].exp_data);
      chk("basic_last", got_l[i], tbl[i].exp_last);
    end
    chk("basic_count_after", intf.cap_count, 5);

    // Backpressure: ready toggles each cycle.
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b111};
    run_capture(1'b0);
    chk("bp_cap_count", intf.cap_count, 4);
    drain(1'b1, 1'b0, 1'b1);
    cmp_drain("bp");

    // Stop while idle has no effect.
    intf.stop = 1'b1;
    tick();
    tick();
    intf.stop = 1'b0;
    chk("idle_stop_busy", intf.busy, 1'b0);
    chk("idle_stop_count", intf.cap_count, 4);
    chk("idle_stop_full", intf.full, 1'b0);
    tick();

    // Empty capture: stop on the first CAPTURE cycle.
    intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    intf.stop  = 1'b1;
    tick();
    intf.stop  = 1'b0;
    intf.rd_ready = 1'b1;
    chk("empty_count", intf.cap_count, 0);
    chk("empty_busy", intf.busy, 1'b0);
    chk("empty_no_valid_0", intf.rd_valid, 1'b0);
    tick();
    chk("empty_no_valid_1", intf.rd_valid, 1'b0);
    // Back in IDLE now, so a start here must be accepted.
    intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    chk("empty_idle_restart", intf.busy, 1'b1);
    intf.stop = 1'b1;
    tick();
    intf.stop = 1'b0;
    tick();
    chk("empty2_no_valid", intf.rd_valid, 1'b0);
    intf.rd_ready = 1'b0;

    // start held through capture and pulsed in drain is ignored.
    exp_q = '{3'b011, 3'b101, 3'b110};
    run_capture(1'b1);
    chk("ign_cap_count", intf.cap_count, 3);
    drain(1'b0, 1'b1, 1'b0);
    cmp_drain("ign");
    chk("ign_count_after", intf.cap_count, 3);
    chk("ign_full_after", intf.full, 1'b0);

    // Overflow: stop never asserted.
    exp_q.delete();
    intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [2:0] v;
      v = 3'((i * 5 + 3) % 8);
      if (i < DEPTH) exp_q.push_back(v);
      set_smp(v);
      tick();
    end
    chk("ovf_cap_count", intf.cap_count, DEPTH);
    chk("ovf_full", intf.full, 1'b1);
    chk("ovf_busy", intf.busy, 1'b0);
    drain(1'b0, 1'b0, 1'b0);
    cmp_drain("ovf");
    chk("ovf_full_after", intf.full, 1'b1);

    // Reset mid-capture at cap_count=10.
    intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_smp(3'(i));
      tick();
    end
    chk("mrst_pre_count", intf.cap_count, 10);
    chk("mrst_pre_busy", intf.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", intf.busy, 1'b0);
    chk("mrst_full", intf.full, 1'b0);
    chk("mrst_count", intf.cap_count, 0);
    chk("mrst_valid", intf.rd_valid, 1'b0);
    chk("mrst_last", intf.rd_last, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = '{3'b100, 3'b001};
    run_capture(1'b0);
    chk("mrst_new_count", intf.cap_count, 2);
    drain(1'b0, 1'b0, 1'b1);
    cmp_drain("mrst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bit_trace_recorder.md
BIT_TRACE_RECORDER -- requirements
Module: bit_trace_recorder

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the number of trace entries; it SHALL be a power of two and at least 4.
REQ-002 Parameter ADDR_W, default 8, SHALL equal log2(DEPTH).
REQ-003 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 start  input  1: level-sampled request to begin a new capture.
REQ-006 stop  input  1: level-sampled request to end the capture.
REQ-007 smp_in  input  1: probed Bit data input.
REQ-008 smp_load  input  1: probed Bit load input.
REQ-009 smp_out  input  1: probed Bit output.
REQ-010 busy  output  1: high in CAPTURE state.
REQ-011 full  output  1: last capture ended because DEPTH entries were stored.
REQ-012 cap_count  output  ADDR_W+1: number of entries stored by the current or last capture.
REQ-013 rd_valid  output  1: rd_data holds a valid trace entry.
REQ-014 rd_data  output  3: trace entry {in, load, out}, same bit order as a 3-bit test vector (bit 2 = in, bit 0 = out).
REQ-015 rd_last  output  1: rd_data is the final stored entry; valid only while rd_valid is high.
REQ-016 rd_ready  input  1: consumer accepts rd_data on a cycle where rd_valid and rd_ready are both high.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, CAPTURE and DRAIN.
REQ-018 IDLE with start=1: next state CAPTURE, cap_count cleared to 0, full cleared to 0; stop ignored in IDLE.
REQ-019 The sample on the cycle start is accepted SHALL NOT be stored; storing begins on the first CAPTURE cycle.
REQ-020 CAPTURE with stop=0: store {smp_in, smp_load, smp_out} at address cap_count[ADDR_W-1:0] and increment cap_count; one entry per clock, no gaps.
REQ-021 CAPTURE with stop=1: store nothing; next state DRAIN.
REQ-022 If a CAPTURE store makes cap_count equal to DEPTH: set full=1; next state DRAIN; no entry overwritten, no wrap-around.
REQ-023 start in CAPTURE or DRAIN SHALL be ignored.
REQ-024 DRAIN SHALL present entries in capture order, addresses 0 to cap_count-1.
REQ-025 The first rd_valid SHALL assert no later than 2 cycles after DRAIN entry.
REQ-026 Each handshake SHALL advance to the next entry with at most 1 bubble cycle.
REQ-027 While rd_valid=1 and rd_ready=0, rd_data and rd_last SHALL hold stable and rd_valid SHALL stay high.
REQ-028 rd_last=1 exactly with entry cap_count-1; after that handshake, rd_valid falls next cycle and the state returns to IDLE.
REQ-029 DRAIN with cap_count=0: rd_valid never asserts; return to IDLE on the next cycle.
REQ-030 cap_count and full SHALL remain readable and unchanged in DRAIN and IDLE until the next accepted start.
REQ-031 Storage SHALL be an internal array of DEPTH x 3 bits; a registered read port is permitted within the REQ-025/026 timing.

Reset
REQ-032 When rst_n=0, the block SHALL asynchronously enter IDLE with busy=0, full=0, cap_count=0, rd_valid=0 and rd_last=0.
REQ-033 rd_data value SHALL be don't-care while rd_valid=0; array contents SHALL NOT require reset.
REQ-034 Reset during CAPTURE or DRAIN SHALL abort the operation; data already stored SHALL NOT be drained after reset.
REQ-035 Release of rst_n SHALL allow start to be accepted on the first subsequent rising edge.

Verification
REQ-036 Basic capture: start, 5 cycles of samples 3'b110,3'b111,3'b011,3'b000,3'b101, then stop, rd_ready=1 -> cap_count=5, full=0, rd_data sequence identical, rd_last only on 3'b101.
REQ-037 Overflow: start, stop held 0 for 300 cycles, DEPTH=256 -> cap_count=256, full=1, exactly 256 entries drained, entry 255 equals the sample of CAPTURE cycle 256.
REQ-038 Backpressure: 4-entry capture, rd_ready toggled 0/1 each cycle -> rd_data and rd_last stable while stalled, 4 handshakes, no duplicate or lost entry.
REQ-039 Empty capture: start, then stop on the first CAPTURE cycle -> cap_count=0, rd_valid never high, busy falls, IDLE within 2 cycles.
REQ-040 Ignored controls: start pulses during CAPTURE and DRAIN, stop in IDLE -> no effect on cap_count, full or drained data.
REQ-041 Mid-operation reset: rst_n low for 1 cycle during CAPTURE with cap_count=10 -> outputs immediately at reset values; a new start/stop of 2 entries then drains exactly 2 entries.
